// File: rtl/bram_arb_pkg.sv
// ---------------------------------------------------------------------------
// bram_arb_pkg
//   Shared types, constants and the arbitration helper for the two-requester
//   BRAM read-port arbiter (bram_read_arbiter).
//
//   Contents
//     req_id_t         1-bit requester identifier (0 or 1)
//     REQ0 / REQ1      named requester ids
//     BRAM_RD_LATENCY  read latency of the shared BRAM port, in cycles
//     NUM_REQ          number of requesters sharing the port
//     arb_pick()       picks the winner from an eligibility vector
// ---------------------------------------------------------------------------
package bram_arb_pkg;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  localparam int BRAM_RD_LATENCY = 1;
  localparam int NUM_REQ         = 2;

  // Winner selection. A single eligible requester always wins; when both are
  // eligible the caller-supplied preference decides (round-robin passes the
  // loser of the previous grant, fixed priority passes REQ0). The result is
  // meaningless when nobody is eligible; callers qualify it with |elig.
  function automatic req_id_t arb_pick(input logic [NUM_REQ-1:0] elig,
                                       input req_id_t            prefer);
    req_id_t id;
    id = REQ0;
    unique case (elig)
      2'b01:   id = REQ0;
      2'b10:   id = REQ1;
      2'b11:   id = prefer;
      default: id = REQ0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/bram_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_read_arbiter_if
//   One requester's connection to the BRAM read arbiter: an address channel
//   (req_*) and a read-data response channel (rsp_*), both valid/ready.
//
//   Signals
//     req_addr   requester -> arbiter  word address
//     req_valid  requester -> arbiter  address valid
//     req_ready  arbiter -> requester  address accepted this cycle
//     rsp_data   arbiter -> requester  read data
//     rsp_valid  arbiter -> requester  read data valid
//     rsp_ready  requester -> arbiter  read data taken
//
//   Modports
//     master  the requesting block
//     slave   the arbiter
// ---------------------------------------------------------------------------
interface bram_read_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) ();

  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_valid;
  logic                  rsp_ready;

  modport master (
    output req_addr,
    output req_valid,
    input  req_ready,
    input  rsp_data,
    input  rsp_valid,
    output rsp_ready
  );

  modport slave (
    input  req_addr,
    input  req_valid,
    output req_ready,
    output rsp_data,
    output rsp_valid,
    input  rsp_ready
  );

endinterface

// File: rtl/bram_arb_rsp_slot.sv
// ---------------------------------------------------------------------------
// bram_arb_rsp_slot
//   Single-entry registered response holder for one requester. Captures BRAM
//   read data when load_i is high and presents it with rsp_valid_o until the
//   requester takes it with rsp_ready_i.
//
//   Ports
//     clk_i         clock, rising edge
//     rst_i         synchronous active-high reset (clears data and valid)
//     load_i        BRAM data for this requester arrives this cycle
//     load_data_i   BRAM read data
//     rsp_ready_i   requester takes the held response this cycle
//     rsp_data_o    held response data
//     rsp_valid_o   held response valid
//     free_o        slot can accept a load on the next edge
// ---------------------------------------------------------------------------
module bram_arb_rsp_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_valid_o,
  output logic                  free_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  // A load on the same edge as a handshake wins, so back-to-back responses
  // keep valid high without a bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && rsp_ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      data_d  = load_data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rsp_data_o  = data_q;
  assign rsp_valid_o = valid_q;
  // Empty, or being emptied this cycle: data loaded next edge is safe.
  assign free_o      = !valid_q || rsp_ready_i;

endmodule

// File: rtl/bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// bram_read_arbiter
//   Shares one BRAM read port (1-cycle read latency) between two requesters.
//   Each requester presents an address with valid/ready and receives the
//   read word through its own registered response slot. The grant is
//   combinational: in the grant cycle the winner sees req_ready, the BRAM
//   sees en and the winner's address, and one cycle later the returning
//   data is written into the winner's slot.
//
//   A requester is eligible only when it has no read in flight and its slot
//   is empty or being drained, so one stalled consumer never blocks the
//   other and each requester has at most one outstanding read.
//
//   Parameters
//     DATA_WIDTH  BRAM / response data width
//     ADDR_WIDTH  BRAM word address width
//
//   Ports
//     aclk               clock, rising edge
//     areset             synchronous active-high reset
//     req0_if, req1_if   requester connections (bram_read_arbiter_if.slave)
//     bram_porta_clk     forwarded aclk
//     bram_porta_rst     forwarded areset
//     bram_porta_en      read enable, high only in a grant cycle
//     bram_porta_addr    granted address (req0 address when idle)
//     bram_porta_rddata  BRAM read data, valid one cycle after en
//
//   Build option
//     BRAM_READ_ARBITER_FIXED_PRIO_EN
//       defined:   requester 0 wins every contention; no last-grant state
//       undefined: round-robin, requester 0 wins the first contention
// ---------------------------------------------------------------------------
module bram_read_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   aclk,
  input  logic                   areset,
  bram_read_arbiter_if.slave     req0_if,
  bram_read_arbiter_if.slave     req1_if,
  output logic                   bram_porta_clk,
  output logic                   bram_porta_rst,
  output logic                   bram_porta_en,
  output logic [ADDR_WIDTH-1:0]  bram_porta_addr,
  input  logic [DATA_WIDTH-1:0]  bram_porta_rddata
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    slot_empty;
  logic [NUM_REQ-1:0]    slot_free;
  logic [NUM_REQ-1:0]    slot_load;
  logic [NUM_REQ-1:0]    eligible;
  logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] rsp_data [NUM_REQ];

  logic                  grant_vld;
  req_id_t               grant_id;
  req_id_t               prefer_id;

  // Read in flight: set in the grant cycle, the data lands on the next edge.
  logic                  pending_q, pending_d;
  req_id_t               pending_id_q, pending_id_d;

  // ---- requester interface unpacking --------------------------------------
  assign req_valid[0] = req0_if.req_valid;
  assign req_valid[1] = req1_if.req_valid;
  assign req_addr[0]  = req0_if.req_addr;
  assign req_addr[1]  = req1_if.req_addr;
  assign rsp_ready[0] = req0_if.rsp_ready;
  assign rsp_ready[1] = req1_if.rsp_ready;

  assign req0_if.req_ready = req_ready[0];
  assign req1_if.req_ready = req_ready[1];
  assign req0_if.rsp_data  = rsp_data[0];
  assign req1_if.rsp_data  = rsp_data[1];
  assign req0_if.rsp_valid = rsp_valid[0];
  assign req1_if.rsp_valid = rsp_valid[1];

  // ---- per-requester eligibility and response slots -----------------------
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign slot_load[i] = pending_q && (pending_id_q == req_id_t'(i));
    assign slot_free[i] = !slot_load[i] && slot_empty[i];
    // Reset blocks new grants so req_ready reads 0 while areset is high.
    assign eligible[i]  = !areset && req_valid[i] && slot_free[i];
    assign req_ready[i] = grant_vld && (grant_id == req_id_t'(i));

    bram_arb_rsp_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk_i       (aclk),
      .rst_i       (areset),
      .load_i      (slot_load[i]),
      .load_data_i (bram_porta_rddata),
      .rsp_ready_i (rsp_ready[i]),
      .rsp_data_o  (rsp_data[i]),
      .rsp_valid_o (rsp_valid[i]),
      .free_o      (slot_empty[i])
    );
  end

  // ---- contention preference ----------------------------------------------
`ifdef BRAM_READ_ARBITER_FIXED_PRIO_EN
  assign prefer_id = REQ0;
`else
  // Reset value REQ1 makes requester 0 win the first contention.
  req_id_t last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      last_grant_d = grant_id;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      last_grant_q <= REQ1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign prefer_id = ~last_grant_q;
`endif

  // ---- grant and BRAM port ------------------------------------------------
  assign grant_vld = |eligible;
  assign grant_id  = arb_pick(eligible, prefer_id);

  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = areset;
  assign bram_porta_en   = grant_vld;
  assign bram_porta_addr = (grant_vld && (grant_id == REQ1)) ? req_addr[1]
                                                             : req_addr[0];

  // ---- in-flight read tracking --------------------------------------------
  // With a one-cycle BRAM, pending simply mirrors the previous cycle's grant;
  // a new grant in the landing cycle keeps it set for the other requester.
  always_comb begin
    pending_d    = grant_vld;
    pending_id_d = pending_id_q;
    if (grant_vld) begin
      pending_id_d = grant_id;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pending_q    <= 1'b0;
      pending_id_q <= REQ0;
    end else begin
      pending_q    <= pending_d;
      pending_id_q <= pending_id_d;
    end
  end

endmodule
